poly_taps_reload_ctrl: RTL

Controller that owns reprogramming of the float32 polynomial estimator datapath (fixed-to-float -> polynomial estimator -> float-to-fixed).
- Holds a CPU-writable shadow bank of G_POLY_ORDER+1 taps.
- On commit, blocks new ADC samples, waits for the in-flight samples to drain, streams the taps into the estimator's tap-programming port, waits for done, then reopens the sample path.
- Sits between the sample source and the datapath input, and observes the datapath output handshake.

---
 rtl/tulip_dsp_pkg.sv | 18 +
 rtl/poly_taps_reload_ctrl_if.sv | 64 ++++++
 rtl/poly_taps_reload_ctrl_inflight.sv | 33 +++
 rtl/poly_taps_reload_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/tulip_dsp_pkg.sv
// Shared types and constants for the float32 polynomial estimator control path.
package tulip_dsp_pkg;

   localparam int C_FP_DWIDTH  = 32;
   localparam int C_ADC_DWIDTH = 24;

   typedef logic [C_FP_DWIDTH-1:0] float_t;

   localparam float_t C_FP_ONE = 32'h3F80_0000;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      LOAD,
      WAIT_DONE
   } ctrl_state_e;

endpackage

// File: rtl/poly_taps_reload_ctrl_if.sv
// Bundles the config, sample-path, monitor and tap-programming signals of the reload controller.
// POLY_TAPS_READBACK_EN adds the shadow readback pair cfg_rd_addr / cfg_rd_data.
interface poly_taps_reload_ctrl_if
   import tulip_dsp_pkg::*;
#(
   parameter int G_POLY_ORDER = 5,
   parameter int G_ADC_DWIDTH = C_ADC_DWIDTH
) ();
   localparam int N  = G_POLY_ORDER + 1;
   localparam int AW = (N > 1) ? $clog2(N) : 1;

   logic                    cfg_wr_en;
   logic [AW-1:0]           cfg_wr_addr;
   float_t                  cfg_wr_data;
   logic                    cfg_commit;
   logic                    cfg_busy;
   logic                    cfg_done_pulse;
   logic                    cfg_timeout_err;
`ifdef POLY_TAPS_READBACK_EN
   logic [AW-1:0]           cfg_rd_addr;
   float_t                  cfg_rd_data;
`endif
   logic [G_ADC_DWIDTH-1:0] s_din;
   logic                    s_din_valid;
   logic                    s_din_ready;
   logic [G_ADC_DWIDTH-1:0] m_din;
   logic                    m_din_valid;
   logic                    m_din_ready;
   logic                    mon_dout_valid;
   logic                    mon_dout_ready;
   float_t                  taps_prog_din;
   logic                    taps_prog_din_valid;
   logic                    taps_prog_din_ready;
   logic                    taps_prog_done;

   // Controller side
   modport slave (
      input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
      input  s_din, s_din_valid, m_din_ready, mon_dout_valid, mon_dout_ready,
      input  taps_prog_din_ready, taps_prog_done,
`ifdef POLY_TAPS_READBACK_EN
      input  cfg_rd_addr,
      output cfg_rd_data,
`endif
      output cfg_busy, cfg_done_pulse, cfg_timeout_err,
      output s_din_ready, m_din, m_din_valid,
      output taps_prog_din, taps_prog_din_valid
   );

   // CPU / sample source / datapath side
   modport master (
      output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
      output s_din, s_din_valid, m_din_ready, mon_dout_valid, mon_dout_ready,
      output taps_prog_din_ready, taps_prog_done,
`ifdef POLY_TAPS_READBACK_EN
      output cfg_rd_addr,
      input  cfg_rd_data,
`endif
      input  cfg_busy, cfg_done_pulse, cfg_timeout_err,
      input  s_din_ready, m_din, m_din_valid,
      input  taps_prog_din, taps_prog_din_valid
   );

endinterface

// File: rtl/poly_taps_reload_ctrl_inflight.sv
// Counts samples inside the datapath: up on input handshake, down on output handshake.
module poly_inflight_counter #(
   parameter int G_MAX_INFLIGHT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o,
   output logic full_o
);
   localparam int CW = $clog2(G_MAX_INFLIGHT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Simultaneous inc+dec cancels; both ends hold rather than wrap
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && (cnt_q != CW'(G_MAX_INFLIGHT)))
         cnt_d = cnt_q + CW'(1);
      else if (dec_i && !inc_i && (cnt_q != '0))
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
   assign full_o = (cnt_q == CW'(G_MAX_INFLIGHT));

endmodule

// File: rtl/poly_taps_reload_ctrl.sv
// Reload controller: shadow tap bank, sample-path gating, drain, tap streaming, done/timeout.
// POLY_TAPS_READBACK_EN adds a registered readback of the shadow bank.
module poly_taps_reload_ctrl
   import tulip_dsp_pkg::*;
#(
   parameter int G_POLY_ORDER   = 5,
   parameter int G_ADC_DWIDTH   = C_ADC_DWIDTH,
   parameter int G_MAX_INFLIGHT = 16,
   parameter int G_DONE_TIMEOUT = 256
) (
   input  logic                    clk,
   input  logic                    reset_n,
   poly_taps_reload_ctrl_if.slave  bus
);
   localparam int N  = G_POLY_ORDER + 1;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = (G_DONE_TIMEOUT > 1) ? $clog2(G_DONE_TIMEOUT) : 1;

   ctrl_state_e             state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    err_q, err_d;
   logic                    done_q, done_d;
   float_t                  shadow_q [N];
   logic [G_ADC_DWIDTH-1:0] din_w;
   logic                    gate, m_hs, mon_hs, infl_zero, infl_full;

   // Sample path only flows while idle and the datapath has room
   assign gate             = (state_q == IDLE) && !infl_full;
   assign din_w            = bus.s_din;
   assign bus.m_din        = din_w;
   assign bus.m_din_valid  = bus.s_din_valid & gate;
   assign bus.s_din_ready  = bus.m_din_ready & gate;
   assign m_hs             = bus.s_din_valid & bus.m_din_ready & gate;
   assign mon_hs           = bus.mon_dout_valid & bus.mon_dout_ready;

   poly_inflight_counter #(
      .G_MAX_INFLIGHT (G_MAX_INFLIGHT)
   ) u_inflight (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   (m_hs),
      .dec_i   (mon_hs),
      .zero_o  (infl_zero),
      .full_o  (infl_full)
   );

   // A write in the commit cycle lands here before LOAD ever reads the bank
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) shadow_q[i] <= (i == 1) ? C_FP_ONE : '0;
      end else if ((state_q == IDLE) && bus.cfg_wr_en && (int'(bus.cfg_wr_addr) < N)) begin
         shadow_q[bus.cfg_wr_addr] <= bus.cfg_wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cfg_commit) begin
               state_d = DRAIN;
               err_d   = 1'b0;
            end
         end
         DRAIN: begin
            if (infl_zero) begin
               state_d = LOAD;
               idx_d   = '0;
            end
         end
         LOAD: begin
            if (bus.taps_prog_din_ready) begin
               if (int'(idx_q) == N - 1) begin
                  state_d = WAIT_DONE;
                  tmo_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         WAIT_DONE: begin
            if (bus.taps_prog_done) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (int'(tmo_q) == G_DONE_TIMEOUT - 1) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign bus.cfg_busy            = (state_q != IDLE);
   assign bus.cfg_done_pulse      = done_q;
   assign bus.cfg_timeout_err     = err_q;
   assign bus.taps_prog_din_valid = (state_q == LOAD);
   assign bus.taps_prog_din       = shadow_q[idx_q];

`ifdef POLY_TAPS_READBACK_EN
   float_t rd_data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         rd_data_q <= '0;
      else if (int'(bus.cfg_rd_addr) < N)   rd_data_q <= shadow_q[bus.cfg_rd_addr];
      else                                  rd_data_q <= '0;
   end

   assign bus.cfg_rd_data = rd_data_q;
`endif

endmodule
